i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 8, i_clk cycles per BCLK half-period (legal 2..255); 1024 i_clk per frame at the default, one frame per mixed sample.
REQ-002 Parameter SAMPLE_BITS, default 24, width of the signed input sample.
REQ-003 i_clk  input  1  system clock; the only clock; all outputs are registers on it.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_sample  input  24  signed mixed sample from the voice mixer; not handshaked, sampled only at capture.
REQ-006 i_gain_shift  input  3  left-shift gain 0..7 applied at capture.
REQ-007 o_bclk  output  1  I2S bit clock.
REQ-008 o_lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-009 o_sdata  output  1  I2S serial data, MSB first.
REQ-010 o_frame_strobe  output  1  one-cycle pulse on the i_clk cycle a sample is captured.
REQ-011 o_clip  output  1  sticky flag, set when any capture saturates, cleared only by reset.

Function
REQ-012 Divider div_cnt counts 0..BCLK_DIV-1 every i_clk; on the cycle it equals BCLK_DIV-1 it wraps to 0 and o_bclk toggles.
REQ-013 A falling event is an o_bclk toggle 1->0; frame position p (6 bits, 0..63) increments by one on each falling event and wraps 63->0.
REQ-014 On each falling event, with p_new the updated value, o_lrclk SHALL become 0 for p_new in {63, 0..30} and 1 for p_new in {31..62}; this gives the I2S one-bit word-select lead.
REQ-015 On the same event o_sdata SHALL become hold[23-p_new] for p_new 0..23, hold[23-(p_new-32)] for p_new 32..55, and 0 otherwise.
REQ-016 Capture occurs on the falling event where p_new = 63: hold <= sat(i_sample <<< i_gain_shift) and o_frame_strobe = 1 for that single cycle.
REQ-017 Saturation: compute exactly in 31 bits; results above 24'sh7FFFFF clamp to 24'sh7FFFFF, results below -24'sh800000 clamp to 24'sh800000; o_clip is set on that capture.
REQ-018 Mono: the left and right slots carry the same hold value; a capture never alters hold mid-frame.
REQ-019 o_lrclk, o_sdata and p change only on falling events; o_bclk, o_lrclk and o_sdata are glitch-free registered outputs.
REQ-020 A change of i_gain_shift or i_sample between captures has no effect until the next capture.

Reset
REQ-021 While i_reset is high: div_cnt=0, o_bclk=0, p=62, o_lrclk=1, o_sdata=0, hold=0, o_frame_strobe=0, o_clip=0.
REQ-022 After release, the first rising o_bclk occurs BCLK_DIV cycles later; the first falling event (p=63, first capture) occurs 2*BCLK_DIV cycles later.
REQ-023 Reset asserted mid-frame aborts the frame immediately; the next cycle shows reset values regardless of p or divider phase.

Structure
REQ-024 Shared include audio_pkg.vh holds FRAME_BCLKS=64, SLOT_BCLKS=32, SAMPLE_BITS=24 and the saturation limits; i2s_tx and the voice mixer both use it.
REQ-025 One sub-module, sat_shift (combinational 24-bit saturating left shift with clip flag), instantiated once; the rest is flat.

Verification
REQ-026 Reset release, BCLK_DIV=8 -> o_bclk rises at cycle 8 and falls at cycle 16, o_frame_strobe pulses at cycle 16, then one pulse every 1024 cycles.
REQ-027 i_sample=24'sh800001, gain 0 -> o_lrclk falls one BCLK before the left MSB; both slots shift 1000...0001 then 8 zeros; o_clip=0.
REQ-028 i_sample=24'sh400000, gain 1 -> slots carry 24'sh7FFFFF and o_clip=1 sticky; a following i_sample=0 gives all zeros with o_clip still 1.
REQ-029 i_sample=-24'sd5, gain 3 -> slots carry 24'shFFFFD8 and o_clip stays 0.
REQ-030 i_sample toggled every cycle mid-frame -> slot data equals the value present on the capture cycle only.
REQ-031 Reset asserted at p=40 -> the next cycle shows o_bclk=0, o_lrclk=1, o_sdata=0, and the first strobe arrives 16 cycles after release.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared audio constants for the I2S transmitter and the voice mixer.
// Frame geometry, sample width and the 24-bit saturation limits.
package i2s_tx_pkg;
  localparam int FRAME_BCLKS = 64;
  localparam int SLOT_BCLKS  = 32;
  localparam int SAMPLE_BITS = 24;
  localparam int WIDE_BITS   = 31;

  localparam logic signed [WIDE_BITS-1:0] SAT_MAX = 31'sd8388607;
  localparam logic signed [WIDE_BITS-1:0] SAT_MIN = -31'sd8388608;
endpackage

// File: rtl/i2s_tx_sat_shift.sv
// Combinational saturating left shift of a signed sample with a clip flag.
// The shift is done exactly in 31 bits before clamping back to 24 bits.
module i2s_tx_sat_shift
  import i2s_tx_pkg::*;
(
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic [2:0]             shift,
  output logic [SAMPLE_BITS-1:0] result,
  output logic                   clip
);
  logic signed [WIDE_BITS-1:0] wide;

  always_comb begin
    wide   = $signed({{(WIDE_BITS-SAMPLE_BITS){sample[SAMPLE_BITS-1]}}, sample}) <<< shift;
    result = wide[SAMPLE_BITS-1:0];
    clip   = 1'b0;
    if (wide > SAT_MAX) begin
      result = SAT_MAX[SAMPLE_BITS-1:0];
      clip   = 1'b1;
    end else if (wide < SAT_MIN) begin
      result = SAT_MIN[SAMPLE_BITS-1:0];
      clip   = 1'b1;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one 64-BCLK frame per captured sample, the same
// 24-bit word in both slots, MSB first with the one-bit word-select lead.
module i2s_tx #(
  parameter int BCLK_DIV    = 8,
  parameter int SAMPLE_BITS = 24
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [SAMPLE_BITS-1:0] i_sample,
  input  logic [2:0]             i_gain_shift,
  output logic                   o_bclk,
  output logic                   o_lrclk,
  output logic                   o_sdata,
  output logic                   o_frame_strobe,
  output logic                   o_clip
);
  import i2s_tx_pkg::*;

  localparam int POS_BITS      = $clog2(FRAME_BCLKS);
  localparam int SLOT_POS_BITS = $clog2(SLOT_BCLKS);

  localparam logic [7:0]               DIV_LAST    = 8'(BCLK_DIV - 1);
  localparam logic [POS_BITS-1:0]      POS_RESET   = POS_BITS'(FRAME_BCLKS - 2);
  localparam logic [POS_BITS-1:0]      POS_CAPTURE = POS_BITS'(FRAME_BCLKS - 1);
  localparam logic [POS_BITS-1:0]      RIGHT_FIRST = POS_BITS'(SLOT_BCLKS - 1);
  localparam logic [POS_BITS-1:0]      RIGHT_LAST  = POS_BITS'(FRAME_BCLKS - 2);
  localparam logic [SLOT_POS_BITS-1:0] WORD_BITS   = SLOT_POS_BITS'(SAMPLE_BITS);
  localparam logic [SLOT_POS_BITS-1:0] MSB_INDEX   = SLOT_POS_BITS'(SAMPLE_BITS - 1);

  logic [7:0]               div_cnt;
  logic [POS_BITS-1:0]      pos;
  logic [POS_BITS-1:0]      pos_next;
  logic [SLOT_POS_BITS-1:0] slot_bit;
  logic [SAMPLE_BITS-1:0]   hold;
  logic [SAMPLE_BITS-1:0]   sat_value;
  logic                     sat_clip;
  logic                     falling;

  i2s_tx_sat_shift u_sat_shift (
    .sample (i_sample),
    .shift  (i_gain_shift),
    .result (sat_value),
    .clip   (sat_clip)
  );

  assign falling  = (div_cnt == DIV_LAST) && o_bclk;
  assign pos_next = pos + 1'b1;
  assign slot_bit = pos_next[SLOT_POS_BITS-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt        <= '0;
      o_bclk         <= 1'b0;
      pos            <= POS_RESET;
      o_lrclk        <= 1'b1;
      o_sdata        <= 1'b0;
      hold           <= '0;
      o_frame_strobe <= 1'b0;
      o_clip         <= 1'b0;
    end else begin
      o_frame_strobe <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        o_bclk  <= ~o_bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      // Everything frame-related moves only on the BCLK falling edge.
      if (falling) begin
        pos     <= pos_next;
        o_lrclk <= (pos_next >= RIGHT_FIRST) && (pos_next <= RIGHT_LAST);
        o_sdata <= (slot_bit < WORD_BITS) ? hold[MSB_INDEX - slot_bit] : 1'b0;
        if (pos_next == POS_CAPTURE) begin
          hold           <= sat_value;
          o_frame_strobe <= 1'b1;
          o_clip         <= o_clip | sat_clip;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx: a cycle-count model of the I2S frame timing
// plus a word scoreboard reassembling both slots from o_sdata.
module tb_i2s_tx;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [23:0] i_sample = '0;
  logic [2:0]  i_gain_shift = '0;
  logic        o_bclk, o_lrclk, o_sdata, o_frame_strobe, o_clip;

  i2s_tx #(.BCLK_DIV(D), .SAMPLE_BITS(24)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_sample       (i_sample),
    .i_gain_shift   (i_gain_shift),
    .o_bclk         (o_bclk),
    .o_lrclk        (o_lrclk),
    .o_sdata        (o_sdata),
    .o_frame_strobe (o_frame_strobe),
    .o_clip         (o_clip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: n = clock edges since reset release.
  int          n;
  int          exp_p;
  logic [23:0] hold_model;
  logic        clip_model;
  logic        exp_bclk, exp_lrclk, exp_sdata, exp_strobe;
  logic [23:0] exp_q[$];

  function automatic int sat_ref(input logic [23:0] s, input int g);
    int v = $signed(s) * (1 << g);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic bit clips(input logic [23:0] s, input int g);
    int v = $signed(s) * (1 << g);
    return (v > 8388607) || (v < -8388608);
  endfunction

  task automatic model_reset();
    n = 0;
    exp_p = 62;
    hold_model = '0;
    clip_model = 1'b0;
    exp_bclk = 1'b0;
    exp_lrclk = 1'b1;
    exp_sdata = 1'b0;
    exp_strobe = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_sample = '0;
    i_gain_shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  // Drive inputs for the next edge, advance one clock and update the model.
  task automatic step(input logic [23:0] s, input logic [2:0] g);
    int m;
    int q;
    i_sample = s;
    i_gain_shift = g;
    @(posedge clk);
    n++;
    m = n / (2 * D);
    exp_strobe = (n % (2 * D) == 0) && (m % 64 == 1);
    if (exp_strobe) begin
      hold_model = 24'(sat_ref(s, int'(g)));
      if (clips(s, int'(g))) clip_model = 1'b1;
      exp_q.push_back(hold_model);
    end
    exp_bclk = ((n / D) % 2) == 1;
    if (m == 0) begin
      exp_p = 62;
      exp_lrclk = 1'b1;
      exp_sdata = 1'b0;
    end else begin
      exp_p = (62 + m) % 64;
      q = exp_p % 32;
      exp_lrclk = (exp_p >= 31) && (exp_p <= 62);
      exp_sdata = (q < 24) ? hold_model[23 - q] : 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      i_reset = 1'b1;
      i_sample = 24'($urandom);
      i_gain_shift = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      checks++;
      if ({o_bclk, o_lrclk, o_sdata, o_frame_strobe, o_clip} !== 5'b01000) begin
        errors++;
        $display("FAIL reset_values cycle %0d got bclk/lr/sd/strb/clip=%b exp 01000", i,
                 {o_bclk, o_lrclk, o_sdata, o_frame_strobe, o_clip});
      end
    end
  endtask

  task automatic test_frame_timing();
    int strobes = 0;
    do_reset();
    for (int i = 0; i < 2100; i++) begin
      step(24'($urandom), 3'($urandom_range(0, 7)));
      if (o_frame_strobe) strobes++;
      checks++;
      if (o_bclk !== exp_bclk) begin
        errors++;
        $display("FAIL bclk n=%0d got %b exp %b", n, o_bclk, exp_bclk);
      end
      checks++;
      if (o_frame_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL strobe n=%0d got %b exp %b", n, o_frame_strobe, exp_strobe);
      end
    end
    checks++;
    if (strobes !== 3) begin
      errors++;
      $display("FAIL strobe_count got %0d exp 3", strobes);
    end
  endtask

  // Fixed vectors, random vectors, then frames whose sample changes every cycle.
  task automatic test_slots();
    logic [23:0] fs[$];
    logic [2:0]  fg[$];
    bit          ft[$];
    logic [23:0] left_w, right_w, want, s;
    fs = '{24'h800001, 24'h400000, 24'h000000, 24'hFFFFFB};
    fg = '{3'd0, 3'd1, 3'd0, 3'd3};
    ft = '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      s = 24'($urandom);
      fs.push_back(24'($signed(s) >>> $urandom_range(0, 23)));
      fg.push_back(3'($urandom_range(0, 7)));
      ft.push_back(k >= 2);
    end
    do_reset();
    left_w = '0;
    right_w = '0;
    for (int k = 0; k < fs.size(); k++) begin
      for (int c = 0; c < 1024; c++) begin
        s = ft[k] ? 24'($urandom) : fs[k];
        step(s, fg[k]);
        checks++;
        if ({o_lrclk, o_sdata, o_frame_strobe} !== {exp_lrclk, exp_sdata, exp_strobe}) begin
          errors++;
          $display("FAIL serial n=%0d p=%0d got lr/sd/strb=%b exp %b", n, exp_p,
                   {o_lrclk, o_sdata, o_frame_strobe}, {exp_lrclk, exp_sdata, exp_strobe});
        end
        checks++;
        if (o_clip !== clip_model) begin
          errors++;
          $display("FAIL clip n=%0d got %b exp %b", n, o_clip, clip_model);
        end
        if (n % (2 * D) == D && n > 2 * D && (exp_p % 32) < 24) begin
          if (exp_p < 32) left_w = {left_w[22:0], o_sdata};
          else right_w = {right_w[22:0], o_sdata};
          if (exp_p == 55) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL word_queue n=%0d got empty exp one entry", n);
            end else begin
              want = exp_q.pop_front();
              if (left_w !== want || right_w !== want) begin
                errors++;
                $display("FAIL slot_word frame %0d got L=%h R=%h exp %h", k, left_w, right_w, want);
              end
            end
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL word_leftover got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_mid_frame_reset();
    int first = -1;
    do_reset();
    for (int i = 0; i < 2000 && exp_p != 40; i++) step(24'($urandom), 3'd1);
    checks++;
    if (exp_p != 40) begin
      errors++;
      $display("FAIL reach_p40 got p=%0d exp 40", exp_p);
    end
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({o_bclk, o_lrclk, o_sdata, o_frame_strobe, o_clip} !== 5'b01000) begin
      errors++;
      $display("FAIL mid_reset got bclk/lr/sd/strb/clip=%b exp 01000",
               {o_bclk, o_lrclk, o_sdata, o_frame_strobe, o_clip});
    end
    i_reset = 1'b0;
    model_reset();
    for (int i = 0; i < 40 && first < 0; i++) begin
      step(24'd7, 3'd0);
      if (o_frame_strobe) first = n;
    end
    checks++;
    if (first != 16) begin
      errors++;
      $display("FAIL first_strobe_after_reset got %0d exp 16", first);
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_slots();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
